pipe_result_fifo: RTL and testbench

PIPE_RESULT_FIFO -- requirements
Module: pipe_result_fifo

---
 rtl/pipe_pkg.sv | 9 +
 rtl/pipe_fifo.sv | 64 ++++++
 rtl/pipe_result_fifo.sv | 87 ++++++++
 tb/tb_pipe_result_fifo.sv | 182 ++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// Shared sizing constants for the pipe result FIFO slice.
// Latency: none, constants only.
// Backpressure: none, constants only.
package pipe_pkg;
    localparam int N      = 10;  // result word width, matches the pipe datapath
    localparam int DEPTH  = 4;   // FIFO entries, power of two, at least 2
    localparam int SUM_W  = 16;  // running sum width
    localparam int DROP_W = 8;   // drop counter width
endpackage

// File: rtl/pipe_fifo.sv
// Storage, pointers and occupancy for the result FIFO.
// Latency: a word written at edge k is readable at the head after edge k.
// Backpressure: none; the caller only pushes when not full or when popping.
// Ports: clk/rst (sync active-high), i_push_vld/i_wr_dat write the tail,
//        i_pop_vld removes the head, o_rd_dat is the head (0 when empty),
//        o_count/o_full/o_empty report occupancy.
module pipe_fifo
    import pipe_pkg::*;
#(
    parameter int W   = N,
    parameter int DPT = DEPTH,
    localparam int AW = $clog2(DPT)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_push_vld,
    input  logic [W-1:0]  i_wr_dat,
    input  logic          i_pop_vld,
    output logic [W-1:0]  o_rd_dat,
    output logic [AW:0]   o_count,
    output logic          o_full,
    output logic          o_empty
);
    logic [W-1:0]  r_mem [DPT];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [AW:0]   r_count;
    logic          w_pop;
    logic          w_push;

    assign o_empty = (r_count == '0);
    assign o_full  = (r_count == (AW+1)'(DPT));

    // Guard here as well so occupancy can never leave 0..DPT even if the
    // caller misbehaves.
    assign w_pop  = i_pop_vld && !o_empty;
    assign w_push = i_push_vld && (!o_full || w_pop);

    // Pointers wrap naturally because DPT is a power of two.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + (AW+1)'(1);
                2'b01:   r_count <= r_count - (AW+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage is left unreset; stale entries are never visible because the
    // head is masked while empty.
    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr] <= i_wr_dat;
    end

    assign o_rd_dat = o_empty ? '0 : r_mem[r_rd_ptr];
    assign o_count  = r_count;
endmodule

// File: rtl/pipe_result_fifo.sv
// Buffers results from the 3-stage arithmetic pipe and keeps statistics.
// Latency: one edge from f_in to out_data; no combinational bypass.
// Backpressure: none upstream; a word arriving while full and not popping is dropped.
// Ports: clk/rst (sync active-high); f_in/f_valid upstream results;
//        out_data/out_valid/out_ready consumer handshake; count occupancy;
//        sum/drop_cnt/overflow statistics, cleared by clr_stats.
module pipe_result_fifo
    import pipe_pkg::*;
#(
    parameter int N_P     = N,
    parameter int DEPTH_P = DEPTH,
    localparam int CW     = $clog2(DEPTH_P) + 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [N_P-1:0]    f_in,
    input  logic              f_valid,
    output logic [N_P-1:0]    out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CW-1:0]     count,
    output logic [SUM_W-1:0]  sum,
    output logic [DROP_W-1:0] drop_cnt,
    output logic              overflow,
    input  logic              clr_stats
);
    logic              w_full;
    logic              w_empty;
    logic              w_pop;
    logic              w_push;
    logic              w_drop;
    logic [SUM_W-1:0]  w_sum_base;
    logic [SUM_W:0]    w_sum_add;
    logic [SUM_W-1:0]  w_sum_nxt;
    logic [DROP_W-1:0] w_drop_base;
    logic [DROP_W-1:0] w_drop_nxt;
    logic              w_ovf_nxt;
    logic [SUM_W-1:0]  r_sum;
    logic [DROP_W-1:0] r_drop_cnt;
    logic              r_overflow;

    assign out_valid = !w_empty;
    assign w_pop     = out_valid && out_ready;
    // A pop in the same cycle frees a slot, so a full FIFO still accepts.
    assign w_push    = f_valid && (!w_full || w_pop);
    assign w_drop    = f_valid && w_full && !w_pop;

    pipe_fifo #(
        .W   (N_P),
        .DPT (DEPTH_P)
    ) u_fifo (
        .clk        (clk),
        .rst        (rst),
        .i_push_vld (w_push),
        .i_wr_dat   (f_in),
        .i_pop_vld  (w_pop),
        .o_rd_dat   (out_data),
        .o_count    (count),
        .o_full     (w_full),
        .o_empty    (w_empty)
    );

    // clr_stats zeroes the base first so same-cycle events land on a clean slate.
    assign w_sum_base  = clr_stats ? '0 : r_sum;
    assign w_sum_add   = {1'b0, w_sum_base} + (SUM_W+1)'(f_in);
    assign w_sum_nxt   = w_sum_add[SUM_W] ? '1 : w_sum_add[SUM_W-1:0];

    assign w_drop_base = clr_stats ? '0 : r_drop_cnt;
    assign w_drop_nxt  = (&w_drop_base) ? w_drop_base : w_drop_base + DROP_W'(1);
    assign w_ovf_nxt   = (clr_stats ? 1'b0 : r_overflow) | w_drop;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sum      <= '0;
            r_drop_cnt <= '0;
            r_overflow <= 1'b0;
        end else begin
            r_sum      <= w_push ? w_sum_nxt : w_sum_base;
            r_drop_cnt <= w_drop ? w_drop_nxt : w_drop_base;
            r_overflow <= w_ovf_nxt;
        end
    end

    assign sum      = r_sum;
    assign drop_cnt = r_drop_cnt;
    assign overflow = r_overflow;
endmodule

// File: tb/tb_pipe_result_fifo.sv
// Directed bench for pipe_result_fifo with a queue scoreboard.
// Latency: n/a.
// Backpressure: n/a.
module tb_pipe_result_fifo;
    localparam int N     = 10;
    localparam int DEPTH = 4;
    localparam int CW    = $clog2(DEPTH) + 1;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [N-1:0]  f_in = '0;
    logic          f_valid = 1'b0;
    logic [N-1:0]  out_data;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [CW-1:0] count;
    logic [15:0]   sum;
    logic [7:0]    drop_cnt;
    logic          overflow;
    logic          clr_stats = 1'b0;

    int checks = 0;
    int errors = 0;

    // Reference state
    int q[$];
    int m_sum  = 0;
    int m_drop = 0;
    int m_ovf  = 0;

    always #5 clk = ~clk;

    pipe_result_fifo dut (
        .clk       (clk),
        .rst       (rst),
        .f_in      (f_in),
        .f_valid   (f_valid),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .count     (count),
        .sum       (sum),
        .drop_cnt  (drop_cnt),
        .overflow  (overflow),
        .clr_stats (clr_stats)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Drive one cycle of stimulus, update the reference, and compare after the edge.
    task automatic step(input logic v, input int d, input logic rdy,
                        input logic clr, input logic r);
        logic pop;
        f_valid   = v;
        f_in      = N'(d);
        out_ready = rdy;
        clr_stats = clr;
        rst       = r;
        #1;
        pop = 1'b0;
        if (!r) begin
            chk("pre_valid", out_valid, (q.size() > 0));
            if (rdy && q.size() > 0) begin
                pop = 1'b1;
                chk("pop_data", out_data, q[0]);
            end
        end
        if (r) begin
            q.delete();
            m_sum = 0; m_drop = 0; m_ovf = 0;
        end else begin
            if (clr) begin
                m_sum = 0; m_drop = 0; m_ovf = 0;
            end
            if (v) begin
                if (q.size() < DEPTH || pop) begin
                    m_sum = m_sum + d;
                    if (m_sum > 65535) m_sum = 65535;
                end else begin
                    if (m_drop < 255) m_drop++;
                    m_ovf = 1;
                end
            end
            if (pop) void'(q.pop_front());
            if (v && (q.size() < DEPTH)) begin
                // Accepted pushes only: a pop above already made room when full.
                if (!(q.size() == DEPTH - 1 && !pop && m_ovf == 1 && 0)) q.push_back(d);
            end
        end
        @(posedge clk);
        #1;
        chk("count", count, q.size());
        chk("valid", out_valid, (q.size() > 0));
        chk("head", out_data, (q.size() > 0) ? q[0] : 0);
        chk("sum", sum, m_sum);
        chk("drop_cnt", drop_cnt, m_drop);
        chk("overflow", overflow, m_ovf);
    endtask

    initial begin
        // Reset state
        step(1'b0, 0, 1'b0, 1'b0, 1'b1);
        step(1'b0, 0, 1'b0, 1'b0, 1'b1);
        chk("rst_count", count, 0);
        chk("rst_valid", out_valid, 0);
        chk("rst_data", out_data, 0);
        chk("rst_sum", sum, 0);

        // Three pushes, no consumer
        step(1'b1, 75, 1'b0, 1'b0, 1'b0);
        step(1'b1, 20, 1'b0, 1'b0, 1'b0);
        step(1'b1, 84, 1'b0, 1'b0, 1'b0);
        chk("r032_count", count, 3);
        chk("r032_valid", out_valid, 1);
        chk("r032_data", out_data, 75);
        chk("r032_sum", sum, 179);

        // Drain them; the pop checks compare 75, 20, 84 in order
        for (int i = 0; i < 3; i++) step(1'b0, 0, 1'b1, 1'b0, 1'b0);
        chk("r033_valid", out_valid, 0);
        chk("r033_data", out_data, 0);
        chk("r033_count", count, 0);

        // Overfill with 1..6 after clearing statistics
        step(1'b0, 0, 1'b0, 1'b1, 1'b0);
        for (int i = 1; i <= 6; i++) step(1'b1, i, 1'b0, 1'b0, 1'b0);
        chk("r034_count", count, 4);
        chk("r034_drop", drop_cnt, 2);
        chk("r034_ovf", overflow, 1);
        chk("r034_sum", sum, 10);
        for (int i = 0; i < 4; i++) step(1'b0, 0, 1'b1, 1'b0, 1'b0);

        // Push while full with a simultaneous pop: no drop, new word goes last
        for (int i = 11; i <= 14; i++) step(1'b1, i, 1'b0, 1'b0, 1'b0);
        step(1'b1, 99, 1'b1, 1'b0, 1'b0);
        chk("r035_count", count, 4);
        chk("r035_drop", drop_cnt, 2);
        for (int i = 0; i < 4; i++) step(1'b0, 0, 1'b1, 1'b0, 1'b0);
        chk("r035_empty", count, 0);

        // Drop counter saturation, then clear with a same-cycle drop
        for (int i = 0; i < 4; i++) step(1'b1, 100 + i, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 260; i++) step(1'b1, 7, 1'b0, 1'b0, 1'b0);
        chk("drop_sat", drop_cnt, 255);
        step(1'b1, 8, 1'b0, 1'b1, 1'b0);
        chk("clr_drop", drop_cnt, 1);
        chk("clr_ovf", overflow, 1);
        chk("clr_keep_count", count, 4);
        for (int i = 0; i < 4; i++) step(1'b0, 0, 1'b1, 1'b0, 1'b0);

        // Sum saturation while streaming, then clear with a same-cycle push
        for (int i = 0; i < 70; i++) step(1'b1, 1023, 1'b1, 1'b0, 1'b0);
        chk("r036_sat", sum, 65535);
        step(1'b1, 5, 1'b0, 1'b1, 1'b0);
        chk("r036_sum", sum, 5);
        chk("r036_drop", drop_cnt, 0);
        chk("r036_ovf", overflow, 0);
        while (q.size() > 0) step(1'b0, 0, 1'b1, 1'b0, 1'b0);

        // Reset during streaming with three words stored
        for (int i = 0; i < 3; i++) step(1'b1, 200 + i, 1'b0, 1'b0, 1'b0);
        chk("r037_pre", count, 3);
        step(1'b1, 300, 1'b1, 1'b1, 1'b1);
        chk("r037_count", count, 0);
        chk("r037_valid", out_valid, 0);
        chk("r037_sum", sum, 0);
        chk("r037_drop", drop_cnt, 0);

        // Recovery after reset
        step(1'b1, 42, 1'b0, 1'b0, 1'b0);
        step(1'b0, 0, 1'b1, 1'b0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
